// File: rtl/sanity_pkg.sv
// Shared types, constants and the item-sequence step function for the sanity stimulus path.
// Optional build macro SANITY_STIM_LFSR_EN swaps the arithmetic sequence for a Galois LFSR.
package sanity_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    HOLD1 = 3'd2,
    HOLD2 = 3'd3,
    GAPW  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int unsigned ITEM_HOLD_CYCLES = 3;
  localparam logic [31:0] LFSR_MASK        = 32'h8020_0003;

  function automatic logic [31:0] next_value(input logic [31:0] cur, input logic [31:0] step);
`ifdef SANITY_STIM_LFSR_EN
    next_value = (cur >> 1) ^ (cur[0] ? LFSR_MASK : 32'h0) ^ (step & 32'h0);
`else
    next_value = cur + step;
`endif
  endfunction

endpackage

// File: rtl/sanity_stim_driver_if.sv
// Strobe/value link from the stimulus driver to the sanity accumulator.
interface sanity_stim_driver_if;
  logic        enable;
  logic [31:0] value;

  modport master (output enable, output value);
  modport slave  (input  enable, input  value);
endinterface

// File: rtl/sanity_shadow_acc.sv
// Running-sum shadow of the consumer's count and LED byte; shared with the receive-side checker.
module sanity_shadow_acc
  import sanity_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        add_en,
  input  logic [31:0] add_val,
  output logic [31:0] count,
  output logic [7:0]  led
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (clr)    count <= '0;
    else if (add_en) count <= count + add_val;
  end

  assign led = count[23:16];

endmodule

// File: rtl/sanity_stim_driver.sv
// Issues a programmable run of one-cycle strobes, each value held for the consumer's 3-cycle window.
// Build macro SANITY_STIM_LFSR_EN selects the LFSR item sequence (seed 0 forced to 1).
module sanity_stim_driver
  import sanity_pkg::*;
#(
  parameter int GAP   = 0,
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  input  logic                 stop,
  input  logic [31:0]          seed,
  input  logic [31:0]          step,
  input  logic [CNT_W-1:0]     num_items,
  sanity_stim_driver_if.master stim,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     items_sent,
  output logic [31:0]          exp_count,
  output logic [7:0]           exp_led
);

  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t           state, state_nxt;
  logic [31:0]      value_q, step_q, seed_eff;
  logic [CNT_W-1:0] num_q;
  logic [3:0]       gap_cnt;
  logic             stop_flag, stop_seen, last_item, launch;

  assign launch    = (state == IDLE) && start;
  assign stop_seen = stop_flag | stop;
  assign last_item = (items_sent + CNT_W'(1)) == num_q;

`ifdef SANITY_STIM_LFSR_EN
  assign seed_eff = (seed == 32'h0) ? 32'h1 : seed;
`else
  assign seed_eff = seed;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (num_items != '0) ? ISSUE : DONE;
      ISSUE: state_nxt = HOLD1;
      HOLD1: state_nxt = HOLD2;
      HOLD2: begin
        if (last_item || stop_seen) state_nxt = DONE;
        else if (GAP > 0)           state_nxt = GAPW;
        else                        state_nxt = ISSUE;
      end
      // stop arriving between items ends the run without another strobe
      GAPW: begin
        if (stop_seen)            state_nxt = DONE;
        else if (gap_cnt == 4'd0) state_nxt = ISSUE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stim.enable = (state == ISSUE);
    stim.value  = value_q;
    busy        = (state != IDLE);
    done        = (state == DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      value_q    <= '0;
      step_q     <= '0;
      num_q      <= '0;
      items_sent <= '0;
      stop_flag  <= 1'b0;
      gap_cnt    <= '0;
    end else if (launch) begin
      step_q     <= step;
      num_q      <= num_items;
      items_sent <= '0;
      stop_flag  <= 1'b0;
      if (num_items != '0) value_q <= seed_eff;
    end else begin
      if ((state inside {ISSUE, HOLD1, HOLD2, GAPW}) && stop) stop_flag <= 1'b1;
      if (state == HOLD2) items_sent <= items_sent + CNT_W'(1);
      if (state != IDLE && state_nxt == ISSUE) value_q <= next_value(value_q, step_q);
      if (state == HOLD2)     gap_cnt <= GAP_LAST;
      else if (state == GAPW) gap_cnt <= gap_cnt - 4'd1;
    end
  end

  // count lands on the same edge as the consumer's update, i.e. on HOLD2 exit
  sanity_shadow_acc u_shadow (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (launch),
    .add_en  (state == HOLD2),
    .add_val (value_q),
    .count   (exp_count),
    .led     (exp_led)
  );

endmodule

// File: tb/tb_sanity_stim_driver.sv
// Bench for sanity_stim_driver: GAP=0 and GAP=2 instances share stimulus; table vectors, random runs, corner sequences.
module tb_sanity_stim_driver;

  localparam int GAP_B = 2;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [31:0] seed = '0, step = '0;
  logic [15:0] num_items = '0;

  sanity_stim_driver_if if0();
  sanity_stim_driver_if if2();

  logic        busy0, done0, busy2, done2;
  logic [15:0] items0, items2;
  logic [31:0] cnt0, cnt2;
  logic [7:0]  led0, led2;

  sanity_stim_driver #(.GAP(0), .CNT_W(16)) dut0 (
    .CLK(clk), .RST_N(rst_n), .start(start), .stop(stop), .seed(seed), .step(step),
    .num_items(num_items), .stim(if0), .busy(busy0), .done(done0),
    .items_sent(items0), .exp_count(cnt0), .exp_led(led0));

  sanity_stim_driver #(.GAP(GAP_B), .CNT_W(16)) dut2 (
    .CLK(clk), .RST_N(rst_n), .start(start), .stop(stop), .seed(seed), .step(step),
    .num_items(num_items), .stim(if2), .busy(busy2), .done(done2),
    .items_sent(items2), .exp_count(cnt2), .exp_led(led2));

  logic        en_a[2], busy_a[2], done_a[2];
  logic [31:0] val_a[2], cnt_a[2];
  logic [15:0] items_a[2];
  logic [7:0]  led_a[2];
  assign en_a[0] = if0.enable;  assign en_a[1] = if2.enable;
  assign val_a[0] = if0.value;  assign val_a[1] = if2.value;
  assign busy_a[0] = busy0;     assign busy_a[1] = busy2;
  assign done_a[0] = done0;     assign done_a[1] = done2;
  assign cnt_a[0] = cnt0;       assign cnt_a[1] = cnt2;
  assign items_a[0] = items0;   assign items_a[1] = items2;
  assign led_a[0] = led0;       assign led_a[1] = led2;

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [31:0] seed;
    logic [31:0] step;
    int          n;
    logic [31:0] cnt;
    logic [31:0] last;
    logic [7:0]  led;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdl_seed(input logic [31:0] s);
`ifdef SANITY_STIM_LFSR_EN
    return (s == 0) ? 32'h1 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [31:0] mdl_next(input logic [31:0] v, input logic [31:0] st);
`ifdef SANITY_STIM_LFSR_EN
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
`else
    return v + st;
`endif
  endfunction

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, " enable"}, {31'b0, en_a[d]}, 0);
      chk({tag, " value"}, val_a[d], 0);
      chk({tag, " busy"}, {31'b0, busy_a[d]}, 0);
      chk({tag, " done"}, {31'b0, done_a[d]}, 0);
      chk({tag, " items_sent"}, {16'b0, items_a[d]}, 0);
      chk({tag, " exp_count"}, cnt_a[d], 0);
      chk({tag, " exp_led"}, {24'b0, led_a[d]}, 0);
    end
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] st, input int n);
    @(negedge clk);
    seed = s; step = st; num_items = 16'(n); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seed = $urandom; step = $urandom; num_items = 16'($urandom);
  endtask

  // Cycle c = 1 is the cycle right after the edge that samples start.
  task automatic run(input logic [31:0] s, input logic [31:0] st, input int n);
    logic [31:0] vals[$];
    logic [31:0] sums[$];
    logic [31:0] v, acc;
    int cd[2], per[2];
    v = mdl_seed(s); acc = 0;
    for (int k = 0; k < n; k++) begin
      vals.push_back(v); acc += v; sums.push_back(acc); v = mdl_next(v, st);
    end
    per[0] = 3; per[1] = 3 + GAP_B;
    for (int d = 0; d < 2; d++) cd[d] = 1 + (n - 1) * per[d] + 3;
    pulse_start(s, st, n);
    for (int c = 1; c <= cd[1] + 1; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (c <= cd[d]) begin
          chk("enable", {31'b0, en_a[d]}, {31'b0, (c < cd[d]) && ((c - 1) % per[d] == 0)});
          chk("done", {31'b0, done_a[d]}, {31'b0, c == cd[d]});
          chk("busy", {31'b0, busy_a[d]}, 1);
          if (c < cd[d]) chk("value", val_a[d], vals[(c - 1) / per[d]]);
          if (c >= 4 && (c - 4) % per[d] == 0 && (c - 4) / per[d] < n) begin
            chk("exp_count", cnt_a[d], sums[(c - 4) / per[d]]);
            chk("exp_led", {24'b0, led_a[d]}, {24'b0, sums[(c - 4) / per[d]][23:16]});
            chk("items_sent", {16'b0, items_a[d]}, (c - 4) / per[d] + 1);
          end
        end else if (c == cd[d] + 1) begin
          chk("idle enable", {31'b0, en_a[d]}, 0);
          chk("idle done", {31'b0, done_a[d]}, 0);
          chk("idle busy", {31'b0, busy_a[d]}, 0);
          chk("held value", val_a[d], vals[n - 1]);
          chk("held exp_count", cnt_a[d], sums[n - 1]);
        end
      end
    end
  endtask

  initial begin
`ifdef SANITY_STIM_LFSR_EN
    tbl.push_back('{32'h0000_0000, 32'h0000_0000, 2, 32'h8020_0004, 32'h8020_0003, 8'h20});
    tbl.push_back('{32'h0000_0001, 32'h1234_5678, 1, 32'h0000_0001, 32'h0000_0001, 8'h00});
    tbl.push_back('{32'h0000_0002, 32'h0000_0000, 3, 32'h8020_0006, 32'h8020_0003, 8'h20});
`else
    tbl.push_back('{32'h0000_0005, 32'h0000_0003, 4, 32'd38,         32'd14,         8'h00});
    tbl.push_back('{32'h0001_0000, 32'h8000_0000, 3, 32'h8003_0000, 32'h0001_0000, 8'h03});
    tbl.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 2, 32'hFFFF_FFFF, 32'h0000_0000, 8'hFF});
    tbl.push_back('{32'h00FF_0000, 32'h0001_0000, 2, 32'h01FF_0000, 32'h0100_0000, 8'hFF});
    tbl.push_back('{32'h0000_0007, 32'h0000_0000, 1, 32'h0000_0007, 32'h0000_0007, 8'h00});
`endif

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop in idle busy", {31'b0, busy0}, 0);

    foreach (tbl[i]) begin
      run(tbl[i].seed, tbl[i].step, tbl[i].n);
      for (int d = 0; d < 2; d++) begin
        chk("tbl exp_count", cnt_a[d], tbl[i].cnt);
        chk("tbl last value", val_a[d], tbl[i].last);
        chk("tbl exp_led", {24'b0, led_a[d]}, {24'b0, tbl[i].led});
        chk("tbl items_sent", {16'b0, items_a[d]}, tbl[i].n);
      end
    end

    // zero items: single-cycle busy/done, no strobe, count cleared
    pulse_start(32'h55, 32'h1, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("zero enable", {31'b0, en_a[d]}, 0);
        chk("zero done", {31'b0, done_a[d]}, {31'b0, c == 1});
        chk("zero busy", {31'b0, busy_a[d]}, {31'b0, c == 1});
        chk("zero exp_count", cnt_a[d], 0);
      end
    end

    // stop during HOLD1 of item 2 (GAP=0 instance); start while busy is ignored
    begin
      logic [31:0] v0, v1;
      v0 = mdl_seed(32'd1000); v1 = mdl_next(v0, 32'd10);
      pulse_start(32'd1000, 32'd10, 10);
      for (int c = 1; c <= 9; c++) begin
        @(negedge clk);
        if (c == 4) begin
          chk("stop item2 enable", {31'b0, en_a[0]}, 1);
          chk("stop item2 value", val_a[0], v1);
        end
        if (c >= 7) chk("stop no strobe", {31'b0, en_a[0]}, 0);
        if (c == 7) begin
          chk("stop done", {31'b0, done_a[0]}, 1);
          chk("stop items_sent", {16'b0, items_a[0]}, 2);
          chk("stop exp_count", cnt_a[0], v0 + v1);
        end
        if (c == 9) chk("stop idle busy", {31'b0, busy_a[0]}, 0);
        if (c == 3) begin seed = 32'hDEAD; num_items = 16'd3; start = 1'b1; end
        if (c == 4) start = 1'b0;
        if (c == 5) stop = 1'b1;
        if (c == 6) stop = 1'b0;
      end
      repeat (4) @(negedge clk);
    end

    // async reset during HOLD2 of item 1, then a clean restart
    pulse_start(32'd100, 32'd1, 5);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    run(32'd100, 32'd1, 2);

    for (int r = 0; r < 8; r++) begin
      logic [31:0] rs, rst;
      rs  = (r % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rst = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 255));
      run(rs, rst, $urandom_range(1, 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
